// File: rtl/snake_pkg.sv
// Shared types and colours for the tile renderer: entity codes, RGB565
// constants, the power-up palette and the cell-fetch FSM state encoding.
package snake_pkg;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        PLAYER    = 2'd1,
        OBJECTIVE = 2'd2,
        WALL      = 2'd3
    } entity_t;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT
    } fetch_state_t;

    localparam logic [15:0] BACKGROUND_COLOR    = 16'h0841;
    localparam logic [15:0] PLAYER_COLOR        = 16'h07E0;
    localparam logic [15:0] OBJECTIVE_COLOR     = 16'hFFE0;
    localparam logic [15:0] BORDER_COLOR_NORMAL = 16'h001F;
    localparam logic [15:0] UNDERRUN_COLOR      = 16'hF81F;
    localparam logic [15:0] GRIDLINE_COLOR      = 16'h39E7;

    localparam logic [15:0] DEFAULT_PALETTE [4] = '{
        BACKGROUND_COLOR, PLAYER_COLOR, OBJECTIVE_COLOR, BORDER_COLOR_NORMAL
    };

    // Palettes wider than four entries power up with background in the extras.
    function automatic logic [15:0] default_color(input int idx);
        if (idx >= 0 && idx < 4)
            return DEFAULT_PALETTE[2'(idx)];
        return BACKGROUND_COLOR;
    endfunction

endpackage

// File: rtl/tile_fetch_fsm.sv
// Cell fetch engine: one outstanding valid/ready request, a single
// overwrite-on-collision pending slot, and the next-entity buffer.
module tile_fetch_fsm
    import snake_pkg::*;
#(
    parameter int ENT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tile_start,
    input  logic [5:0]       i_nxt_x,
    input  logic [5:0]       i_nxt_y,
    input  logic             i_req_ready,
    input  logic             i_resp_valid,
    input  logic [ENT_W-1:0] i_resp_entity,
    output logic             o_req_valid,
    output logic [5:0]       o_req_x,
    output logic [5:0]       o_req_y,
    output logic             o_resp_fire,
    output logic [ENT_W-1:0] o_nxt_ent,
    output logic             o_nxt_vld
);

    fetch_state_t     r_state, w_state_nxt;
    logic             w_issue;
    logic             r_pend;
    logic [5:0]       r_pend_x, r_pend_y, r_req_x, r_req_y;
    logic [ENT_W-1:0] r_nxt_ent;
    logic             r_nxt_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= FS_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        o_req_valid = 1'b0;
        o_resp_fire = 1'b0;
        case (r_state)
            FS_IDLE: begin
                if (i_tile_start || r_pend) begin
                    w_state_nxt = FS_REQ;
                    w_issue     = 1'b1;
                end
            end
            FS_REQ: begin
                o_req_valid = 1'b1;
                if (i_req_ready) w_state_nxt = FS_WAIT;
            end
            FS_WAIT: begin
                o_resp_fire = i_resp_valid;
                if (i_resp_valid) w_state_nxt = FS_IDLE;
            end
            default: w_state_nxt = FS_IDLE;
        endcase
    end

    // Out of reset the slot already holds cell (0,0) so the first pixel has data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 1'b1;
            r_pend_x  <= '0;
            r_pend_y  <= '0;
            r_req_x   <= '0;
            r_req_y   <= '0;
            r_nxt_ent <= '0;
            r_nxt_vld <= 1'b0;
        end else begin
            if (w_issue) begin
                // A fresh tile start outranks anything older in the slot.
                r_req_x <= i_tile_start ? i_nxt_x : r_pend_x;
                r_req_y <= i_tile_start ? i_nxt_y : r_pend_y;
                r_pend  <= 1'b0;
            end else if (i_tile_start) begin
                r_pend   <= 1'b1;
                r_pend_x <= i_nxt_x;
                r_pend_y <= i_nxt_y;
            end
            // The swap consumes the buffer (or a same-cycle response) at tile start.
            if (i_tile_start) begin
                r_nxt_vld <= 1'b0;
            end else if (o_resp_fire) begin
                r_nxt_vld <= 1'b1;
                r_nxt_ent <= i_resp_entity;
            end
        end
    end

    assign o_req_x   = r_req_x;
    assign o_req_y   = r_req_y;
    assign o_nxt_ent = r_nxt_ent;
    assign o_nxt_vld = r_nxt_vld;

endmodule

// File: rtl/tile_renderer.sv
// Tile-grid RGB565 renderer with one-tile-ahead entity prefetch and a
// writable palette. Optional grid overlay: TILE_RENDERER_GRIDLINES_EN.
module tile_renderer
    import snake_pkg::*;
#(
    parameter int TILE_LOG2 = 3,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int X_W       = 10,
    parameter int ENT_W     = 2,
    parameter int COLOR_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [X_W-1:0]     x,
    input  logic [X_W-1:0]     y,
    input  logic               de,
    output logic               req_valid,
    output logic [5:0]         req_x,
    output logic [5:0]         req_y,
    input  logic               req_ready,
    input  logic               resp_valid,
    input  logic [ENT_W-1:0]   resp_entity,
    input  logic               pal_we,
    input  logic [ENT_W-1:0]   pal_idx,
    input  logic [COLOR_W-1:0] pal_color,
    output logic [COLOR_W-1:0] pixel_data,
    output logic               underrun
);

    localparam int             NPAL    = 2 ** ENT_W;
    localparam logic [X_W-1:0] GW      = X_W'(GRID_W);
    localparam logic [X_W-1:0] GW_LAST = X_W'(GRID_W - 1);
    localparam logic [X_W-1:0] GH      = X_W'(GRID_H);

    logic [X_W-1:0]       w_cx, w_cy, w_y1, w_ny;
    logic [TILE_LOG2-1:0] w_off;
    logic                 w_tile_start, w_in_grid, w_avail, w_urun, w_resp_fire, w_nxt_vld;
    logic [5:0]           w_nxt_x, w_nxt_y;
    logic [ENT_W-1:0]     w_nxt_ent, w_new_ent, w_ent;
    logic [COLOR_W-1:0]   w_pix;

    logic [COLOR_W-1:0]   r_pal [NPAL];
    logic [ENT_W-1:0]     r_cur_ent;
    logic                 r_urun_tile, r_underrun;
    logic [COLOR_W-1:0]   r_pix;

    assign w_cx         = x >> TILE_LOG2;
    assign w_cy         = y >> TILE_LOG2;
    assign w_off        = x[TILE_LOG2-1:0];
    assign w_tile_start = de && (w_off == '0);
    assign w_y1         = y + X_W'(1);
    assign w_ny         = w_y1 >> TILE_LOG2;
    assign w_in_grid    = (w_cx < GW) && (w_cy < GH);

    // Past the last column the next cell is the start of the row under the
    // following scanline, so each scanline refetches its row and the frame wraps.
    always_comb begin
        if (w_cx < GW_LAST) begin
            w_nxt_x = 6'(w_cx + X_W'(1));
            w_nxt_y = 6'(w_cy);
        end else begin
            w_nxt_x = '0;
            w_nxt_y = (w_ny >= GH) ? 6'd0 : 6'(w_ny);
        end
    end

    tile_fetch_fsm #(.ENT_W(ENT_W)) u_fetch (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_tile_start  (w_tile_start),
        .i_nxt_x       (w_nxt_x),
        .i_nxt_y       (w_nxt_y),
        .i_req_ready   (req_ready),
        .i_resp_valid  (resp_valid),
        .i_resp_entity (resp_entity),
        .o_req_valid   (req_valid),
        .o_req_x       (req_x),
        .o_req_y       (req_y),
        .o_resp_fire   (w_resp_fire),
        .o_nxt_ent     (w_nxt_ent),
        .o_nxt_vld     (w_nxt_vld)
    );

    assign w_avail   = w_nxt_vld || w_resp_fire;
    assign w_new_ent = w_resp_fire ? resp_entity : w_nxt_ent;
    assign w_ent     = w_tile_start ? w_new_ent : r_cur_ent;
    assign w_urun    = w_tile_start ? !w_avail : r_urun_tile;

    always_comb begin
        w_pix = r_pal[w_ent];
        if (!de)
            w_pix = '0;
        else if (w_urun)
            w_pix = COLOR_W'(UNDERRUN_COLOR);
        else if (!w_in_grid)
            w_pix = COLOR_W'(BACKGROUND_COLOR);
`ifdef TILE_RENDERER_GRIDLINES_EN
        else if (w_off == '0 || y[TILE_LOG2-1:0] == '0)
            w_pix = COLOR_W'(GRIDLINE_COLOR);
`endif
    end

    // Palette read above sees the pre-write value, so a write shows from the next pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPAL; i++) r_pal[i] <= COLOR_W'(default_color(i));
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_color;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_ent   <= '0;
            r_urun_tile <= 1'b0;
            r_underrun  <= 1'b0;
            r_pix       <= '0;
        end else begin
            r_pix <= w_pix;
            if (w_tile_start) begin
                r_urun_tile <= !w_avail;
                if (w_avail) r_cur_ent  <= w_new_ent;
                else         r_underrun <= 1'b1;
            end
        end
    end

    assign pixel_data = r_pix;
    assign underrun   = r_underrun;

endmodule
